ln4017_rx: RTL and testbench
============================

# ln4017_rx

Receive-side companion to the ln4017 decade counter: samples the counter's ten decoded outputs and its carry line, converts the one-hot state back into a BCD digit, and checks that the sequence advances legally. Accumulates completed decades and reports lock and error status. It sits between a (possibly remote) ln4017 and downstream logic that needs a binary count, or a health indication, rather than ten separate lines.

## Interface
Parameters:
- DECADE_W, 8: width of the completed-decade accumulator.
- LOCK_CNT, 3: consecutive legal samples required to enter LOCKED (1..15).

Ports:
- cp0, in, 1: clock, rising edge.
- mr_b, in, 1: asynchronous, active-low reset.
- sample_en, in, 1: qualifies the current cycle's out_q/q59_b as a sample.
- out_q, in, 10: one-hot state from ln4017 (bit n high = state n).
- q59_b, in, 1: ln4017 carry; high in states 0-4, low in states 5-9.
- bcd, out, 4: last legal decoded digit, 0-9.
- locked, out, 1: high while in LOCKED.
- seq_err, out, 1: one-cycle pulse on an illegal transition while LOCKED.
- onehot_err, out, 1: one-cycle pulse on a non-one-hot sample (any state).
- wrap, out, 1: one-cycle pulse on each 9->0 transition while LOCKED.
- decades, out, DECADE_W: count of 9->0 transitions seen while LOCKED.
- ovf, out, 1: sticky; set when decades wraps from all-ones to 0.

## Operation
- Stage 1: on each cp0 edge with sample_en=1, register out_q and q59_b, and set an internal sample-valid flag. With sample_en=0, sample-valid clears and every downstream state holds.
- Stage 2 acts on a valid stage-1 sample:
  - Legal one-hot: exactly one bit set. Otherwise pulse onehot_err; if LOCKED, also pulse seq_err and go to ACQUIRE. bcd holds.
  - Legal transition from the previous digit p: new = p (hold, because the counter's cp1 inhibit is allowed) or new = (p+1) mod 10.
- State machine:
  - ACQUIRE (reset state): the first one-hot sample loads bcd and sets good-count to 1. Each further legal transition increments good-count. An illegal transition reloads bcd with the new digit and sets good-count to 1. When good-count reaches LOCK_CNT, go to LOCKED. seq_err, wrap and decades are inactive in ACQUIRE.
  - LOCKED: a legal transition updates bcd. A 9->0 transition pulses wrap and increments decades, with modulo wrap; on wrap to 0, set ovf. An illegal transition pulses seq_err, loads bcd with the new digit, sets good-count to 1 and goes to ACQUIRE.
- Holds (new = p) count as legal in both states. In ACQUIRE they increment good-count.
- Simultaneous errors: one sample may pulse onehot_err and seq_err together. A non-one-hot sample never pulses wrap.

## Timing
- Reset values (async, mr_b=0): bcd=0, locked=0, seq_err=0, onehot_err=0, wrap=0, decades=0, ovf=0, state=ACQUIRE, good-count=0, sample-valid=0.
- Latency: a sample taken at edge k is reflected in bcd, flags and pulses after edge k+1, i.e. 2 cycles from the input.
- locked rises after the edge that processes the LOCK_CNT-th legal sample.
- Reset mid-operation: all state clears immediately and any in-flight stage-1 sample is discarded. The first sample after release starts a fresh acquisition.
- Pulses last exactly one cycle, even when sample_en stays high with a constant input.

## Configuration
- LN4017_CARRY_CHECK_EN defined: each one-hot sample also checks q59_b against the state; it must be 1 for states 0-4 and 0 for states 5-9. A mismatch is treated as an illegal transition: seq_err pulses if LOCKED, and the block returns to ACQUIRE. In ACQUIRE, a mismatch sets good-count to 0 and leaves bcd unchanged.
- LN4017_CARRY_CHECK_EN undefined: q59_b is ignored; it is registered but unused.

## Test plan
- Reset and lock: hold mr_b=0, then release. Feed states 0,1,2 with sample_en=1. Expect locked=1 two cycles after the state-2 sample and bcd=2; no pulses.
- Full wrap: once locked, step 3..9 then 0. Expect one wrap pulse, decades=1, bcd=0; repeat 256 times with DECADE_W=8 and expect decades=0 and ovf=1.
- Hold and gating: once locked at 4, present 4 for 5 samples, then sample_en=0 for 10 cycles while presenting 7. Expect bcd=4, locked=1 and no seq_err throughout.
- Skip error: once locked at 5, present 7. Expect a seq_err pulse, locked=0 and bcd=7. Then 8,9 give locked=1 again with LOCK_CNT=3.
- Non-one-hot: present 10'b0000000000, then 10'b0000100001 while locked. Expect onehot_err pulses on both samples, seq_err on the first, locked=0 and bcd unchanged.
- Carry check, with LN4017_CARRY_CHECK_EN defined: once locked at 6, present state 7 with q59_b=1. Expect a seq_err pulse and locked=0. Without the macro, the same stimulus gives bcd=7, locked=1 and no pulse.

Source files
------------

// File: rtl/ln4017_rx.sv
// rtl/ln4017_rx.sv - ln4017 decade counter receiver: one-hot to BCD, sequence check, lock and decade count
// Optional build macro: LN4017_CARRY_CHECK_EN (cross-checks q59_b against the decoded state)
module ln4017_rx #(
    parameter int DECADE_W = 8,
    parameter int LOCK_CNT = 3
) (
    input  logic                cp0,
    input  logic                mr_b,
    input  logic                sample_en,
    input  logic [9:0]          out_q,
    input  logic                q59_b,
    output logic [3:0]          bcd,
    output logic                locked,
    output logic                seq_err,
    output logic                onehot_err,
    output logic                wrap,
    output logic [DECADE_W-1:0] decades,
    output logic                ovf
);

    typedef enum logic {
        ACQUIRE = 1'b0,
        LOCKED  = 1'b1
    } state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);

    state_t              state, state_nx;
    logic [9:0]          s_q;
    logic                s_carry;
    logic                s_valid;
    logic [3:0]          good, good_nx;
    logic [3:0]          bcd_nx;
    logic                seq_nx, onehot_nx, wrap_nx, ovf_nx;
    logic [DECADE_W-1:0] decades_nx;

    logic                is_onehot;
    logic [3:0]          digit;
    logic [3:0]          bcd_inc;
    logic                legal;
    logic                carry_ok;

    assign locked = (state == LOCKED);

    // Stage 1: capture the counter lines; the valid flag drops on any unqualified cycle
    always_ff @(posedge cp0 or negedge mr_b) begin
        if (!mr_b) begin
            s_valid <= 1'b0;
            s_q     <= '0;
            s_carry <= 1'b0;
        end else begin
            s_valid <= sample_en;
            if (sample_en) begin
                s_q     <= out_q;
                s_carry <= q59_b;
            end
        end
    end

    // Decode the captured sample and judge it against the last accepted digit
    always_comb begin
        digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (s_q[i]) digit = 4'(i);
        end
        is_onehot = (s_q != 10'd0) && ((s_q & (s_q - 10'd1)) == 10'd0);
        bcd_inc   = (bcd == 4'd9) ? 4'd0 : bcd + 4'd1;
        legal     = (digit == bcd) || (digit == bcd_inc);
`ifdef LN4017_CARRY_CHECK_EN
        // q59_b is high exactly in states 0-4
        carry_ok  = (s_carry == (digit < 4'd5));
`else
        carry_ok  = 1'b1;
`endif
    end

`ifndef LN4017_CARRY_CHECK_EN
    logic unused_carry;
    assign unused_carry = s_carry;
`endif

    // Stage 2 next-state: acquisition/lock FSM, digit tracking, pulses and decade accumulator.
    // good == 0 in ACQUIRE means there is no reference digit yet, so the next one-hot sample just loads.
    always_comb begin
        state_nx   = state;
        good_nx    = good;
        bcd_nx     = bcd;
        seq_nx     = 1'b0;
        onehot_nx  = 1'b0;
        wrap_nx    = 1'b0;
        decades_nx = decades;
        ovf_nx     = ovf;
        if (s_valid) begin
            if (!is_onehot) begin
                onehot_nx = 1'b1;
                good_nx   = 4'd0;
                if (state == LOCKED) begin
                    seq_nx   = 1'b1;
                    state_nx = ACQUIRE;
                end
            end else if (!carry_ok) begin
                // A carry mismatch breaks the chain but does not supply a trustworthy digit
                good_nx = 4'd0;
                if (state == LOCKED) begin
                    seq_nx   = 1'b1;
                    state_nx = ACQUIRE;
                end
            end else if (state == ACQUIRE) begin
                bcd_nx = digit;
                if ((good == 4'd0) || !legal) begin
                    good_nx = 4'd1;
                end else begin
                    good_nx = (good == 4'd15) ? good : good + 4'd1;
                end
                if (good_nx >= LOCK_N) begin
                    state_nx = LOCKED;
                end
            end else if (legal) begin
                bcd_nx = digit;
                if ((bcd == 4'd9) && (digit == 4'd0)) begin
                    wrap_nx    = 1'b1;
                    decades_nx = decades + DECADE_W'(1);
                    if (decades == {DECADE_W{1'b1}}) begin
                        ovf_nx = 1'b1;
                    end
                end
            end else begin
                seq_nx   = 1'b1;
                bcd_nx   = digit;
                good_nx  = 4'd1;
                state_nx = ACQUIRE;
            end
        end
    end

    // Stage 2 registers: pulses are rewritten every cycle so they never stretch
    always_ff @(posedge cp0 or negedge mr_b) begin
        if (!mr_b) begin
            state      <= ACQUIRE;
            good       <= 4'd0;
            bcd        <= 4'd0;
            seq_err    <= 1'b0;
            onehot_err <= 1'b0;
            wrap       <= 1'b0;
            decades    <= '0;
            ovf        <= 1'b0;
        end else begin
            state      <= state_nx;
            good       <= good_nx;
            bcd        <= bcd_nx;
            seq_err    <= seq_nx;
            onehot_err <= onehot_nx;
            wrap       <= wrap_nx;
            decades    <= decades_nx;
            ovf        <= ovf_nx;
        end
    end

endmodule

// File: tb/tb_ln4017_rx.sv
// tb/tb_ln4017_rx.sv - self-checking bench for ln4017_rx: vector table, directed sequences, random walk vs model
module tb_ln4017_rx;

    localparam int DW = 8;
    localparam int LC = 3;

    logic          clk = 1'b0;
    logic          mr_b = 1'b0;
    logic          sample_en = 1'b0;
    logic [9:0]    out_q = 10'd0;
    logic          q59_b = 1'b0;
    logic [3:0]    bcd;
    logic          locked, seq_err, onehot_err, wrap, ovf;
    logic [DW-1:0] decades;

    ln4017_rx #(.DECADE_W(DW), .LOCK_CNT(LC)) dut (
        .cp0(clk), .mr_b(mr_b), .sample_en(sample_en), .out_q(out_q), .q59_b(q59_b),
        .bcd(bcd), .locked(locked), .seq_err(seq_err), .onehot_err(onehot_err),
        .wrap(wrap), .decades(decades), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: digits as integers, one pending sample between edges
    bit         pv;
    logic [9:0] pq;
    bit         pc;
    int         m_bcd, m_good, m_dec;
    bit         m_locked, m_ovf, e_seq, e_oh, e_wrap;

    typedef struct {
        bit         en;
        logic [9:0] q;
        bit         c;
        int         bcd;
        bit         lk, seq, oh, wr;
        int         dec;
    } vec_t;

    vec_t tbl[15];

    function automatic logic [9:0] oh(int d);
        logic [9:0] one;
        one = 10'd1;
        return one << d;
    endfunction

    function automatic bit cf(int d);
        return d < 5;
    endfunction

    function automatic vec_t mk(bit en, logic [9:0] q, bit c, int b, bit lk, bit seq, bit o, bit wr, int dec);
        vec_t v;
        v.en = en; v.q = q; v.c = c; v.bcd = b; v.lk = lk; v.seq = seq; v.oh = o; v.wr = wr; v.dec = dec;
        return v;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        pv = 0; pq = 10'd0; pc = 0;
        m_bcd = 0; m_good = 0; m_dec = 0;
        m_locked = 0; m_ovf = 0; e_seq = 0; e_oh = 0; e_wrap = 0;
    endtask

    function automatic void model_sample(logic [9:0] q, bit c);
        int d;
        bit legal, carry_bad;
        if ($countones(q) != 1) begin
            e_oh = 1;
            m_good = 0;
            if (m_locked) begin e_seq = 1; m_locked = 0; end
            return;
        end
        d = $clog2(q);
        carry_bad = 0;
`ifdef LN4017_CARRY_CHECK_EN
        carry_bad = (c != (d < 5));
`endif
        if (carry_bad) begin
            m_good = 0;
            if (m_locked) begin e_seq = 1; m_locked = 0; end
            return;
        end
        legal = (d == m_bcd) || (d == (m_bcd + 1) % 10);
        if (!m_locked) begin
            if (m_good > 0 && legal) m_good++;
            else m_good = 1;
            m_bcd = d;
            if (m_good >= LC) m_locked = 1;
        end else if (legal) begin
            if (m_bcd == 9 && d == 0) begin
                e_wrap = 1;
                m_dec = (m_dec + 1) % (1 << DW);
                if (m_dec == 0) m_ovf = 1;
            end
            m_bcd = d;
        end else begin
            e_seq = 1; m_bcd = d; m_good = 1; m_locked = 0;
        end
    endfunction

    task automatic model_edge(input bit en, input logic [9:0] q, input bit c);
        e_seq = 0; e_oh = 0; e_wrap = 0;
        if (pv) model_sample(pq, pc);
        pv = en; pq = q; pc = c;
    endtask

    task automatic check_model();
        int got, exp;
        got = {bcd, locked, seq_err, onehot_err, wrap, ovf, decades};
        exp = {4'(m_bcd), m_locked, e_seq, e_oh, e_wrap, m_ovf, DW'(m_dec)};
        check("model {bcd,lk,seq,oh,wrap,ovf,dec}", got, exp);
    endtask

    task automatic step(input bit en, input logic [9:0] q, input bit c);
        sample_en = en; out_q = q; q59_b = c;
        @(posedge clk);
        model_edge(en, q, c);
        #1;
        check_model();
    endtask

    task automatic step_d(input int d);
        step(1'b1, oh(d), cf(d));
    endtask

    task automatic check_zero(input string name);
        check(name, {bcd, locked, seq_err, onehot_err, wrap, ovf, decades}, 0);
    endtask

    // Asynchronous reset mid-cycle with a sample offered, released on a falling edge
    task automatic do_reset();
        sample_en = 1'b1; out_q = oh(3); q59_b = 1'b1;
        #2 mr_b = 1'b0;
        #1 check_zero("reset_async");
        @(posedge clk);
        @(posedge clk);
        #1 check_zero("reset_hold");
        @(negedge clk);
        mr_b = 1'b1;
        model_reset();
    endtask

    initial begin
        int d, r;
        bit en, c;
        logic [9:0] q;

        model_reset();
        #2 check_zero("reset_initial");
        @(negedge clk);
        mr_b = 1'b1;

        // Lock, skip error, wrap, hold, non-one-hot, gating
        tbl[0]  = mk(1, oh(0), 1, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, oh(1), 1, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, oh(2), 1, 1, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, oh(3), 1, 2, 1, 0, 0, 0, 0);
        tbl[4]  = mk(1, oh(4), 1, 3, 1, 0, 0, 0, 0);
        tbl[5]  = mk(1, oh(5), 0, 4, 1, 0, 0, 0, 0);
        tbl[6]  = mk(1, oh(7), 0, 5, 1, 0, 0, 0, 0);
        tbl[7]  = mk(1, oh(8), 0, 7, 0, 1, 0, 0, 0);
        tbl[8]  = mk(1, oh(9), 0, 8, 0, 0, 0, 0, 0);
        tbl[9]  = mk(1, oh(0), 1, 9, 1, 0, 0, 0, 0);
        tbl[10] = mk(1, oh(0), 1, 0, 1, 0, 0, 1, 1);
        tbl[11] = mk(1, 10'b0000000000, 1, 0, 1, 0, 0, 0, 1);
        tbl[12] = mk(1, 10'b0000100001, 1, 0, 0, 1, 1, 0, 1);
        tbl[13] = mk(0, oh(3), 1, 0, 0, 0, 1, 0, 1);
        tbl[14] = mk(0, oh(7), 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].en, tbl[i].q, tbl[i].c);
            check($sformatf("vec%0d {bcd,lk,seq,oh,wrap,dec}", i),
                  {bcd, locked, seq_err, onehot_err, wrap, decades},
                  {4'(tbl[i].bcd), tbl[i].lk, tbl[i].seq, tbl[i].oh, tbl[i].wr, DW'(tbl[i].dec)});
        end

        // Hold and gating: lock at 4, hold 4, then ignore 7 while sample_en is low
        step_d(2); step_d(3); step_d(4);
        for (int i = 0; i < 5; i++) step_d(4);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, oh(7), 1'b0);
            check("gate_bcd", bcd, 4);
            check("gate_locked", locked, 1);
        end

        // Reset with a sample in flight: it must be discarded
        step_d(5);
        do_reset();
        step(1'b0, oh(7), 1'b0);
        check("post_reset_bcd", bcd, 0);
        check("post_reset_locked", locked, 0);
        step_d(7);
        step(1'b0, oh(7), 1'b0);
        check("fresh_acq_bcd", bcd, 7);

        // 256 decades: counter returns to zero and overflow sticks
        do_reset();
        step_d(0); step_d(1); step_d(2);
        for (int w = 0; w < 256; w++) begin
            for (int k = (w == 0) ? 3 : 1; k <= 9; k++) begin
                step_d(k);
                if (w == 1 && k == 1) begin
                    check("first_wrap_pulse", wrap, 1);
                    check("first_wrap_decades", decades, 1);
                    check("first_wrap_ovf", ovf, 0);
                end
            end
            step_d(0);
        end
        step_d(1);
        check("wrap256_pulse", wrap, 1);
        check("wrap256_decades", decades, 0);
        check("wrap256_ovf", ovf, 1);
        check("wrap256_bcd", bcd, 0);
        step_d(1);
        check("ovf_sticky", ovf, 1);
        check("wrap_one_cycle", wrap, 0);

        // Carry line disagreeing with state 7
        do_reset();
        step_d(4); step_d(5); step_d(6);
        step(1'b1, oh(7), 1'b1);
        step(1'b0, oh(7), 1'b1);
`ifdef LN4017_CARRY_CHECK_EN
        check("carry_seq_err", seq_err, 1);
        check("carry_locked", locked, 0);
`else
        check("carry_bcd", bcd, 7);
        check("carry_locked", locked, 1);
        check("carry_seq_err", seq_err, 0);
`endif

        // Random walk with occasional faults and gaps
        do_reset();
        d = 0;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            en = ($urandom_range(0, 99) < 85);
            if (r < 60) begin
                if ($urandom_range(0, 2) != 0) d = (d + 1) % 10;
                q = oh(d); c = cf(d);
            end else if (r < 68) begin
                d = $urandom_range(0, 9);
                q = oh(d); c = cf(d);
            end else if (r < 73) begin
                q = 10'($urandom);
                c = 1'($urandom);
            end else if (r < 77) begin
                q = oh(d); c = !cf(d);
            end else begin
                q = oh(d); c = cf(d);
            end
            step(en, q, c);
        end
        step(1'b0, 10'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
